// File: rtl/uart_rx_arbiter.sv
// Round-robin drain of NUM_PORTS UART RX FIFOs into one tagged character stream.
// Optional feature macro UART_RX_ARB_DROP_ERR_EN: discard parity/framing-error words instead of offering them.
module uart_rx_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int CNT_W     = 5,
  parameter int REC_W     = 11,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       port_en,
  input  logic [NUM_PORTS*CNT_W-1:0] rf_count,
  input  logic [NUM_PORTS*REC_W-1:0] rf_data_out,
  output logic [NUM_PORTS-1:0]       rf_pop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [PORT_W-1:0]          out_port,
  output logic [2:0]                 out_status,
  output logic                       grant_busy,
  output logic                       err_drop
);

  typedef enum logic [1:0] {ARB, FETCH, OFFER, DROP} state_t;

  state_t            state;
  logic [PORT_W-1:0] rr_ptr;
  logic [PORT_W-1:0] grant;
  logic [3:0]        burst_cnt;

  logic [NUM_PORTS-1:0] elig;
  logic                 hit;
  logic [PORT_W-1:0]    hit_idx;
  logic [REC_W-1:0]     head;
  logic                 grant_elig;
  logic                 burst_more;
  logic [PORT_W-1:0]    grant_next;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PORT_W-1:0] p);
    logic [NUM_PORTS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      elig[i] = port_en[i] && (rf_count[i*CNT_W +: CNT_W] != '0);
  end

  // First eligible port at or after rr_ptr, wrapping past NUM_PORTS-1.
  always_comb begin
    logic [PORT_W:0]   sum;
    logic [PORT_W-1:0] idx;
    hit     = 1'b0;
    hit_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, rr_ptr} + (PORT_W+1)'(k);
      if (sum >= (PORT_W+1)'(NUM_PORTS))
        sum = sum - (PORT_W+1)'(NUM_PORTS);
      idx = sum[PORT_W-1:0];
      if (!hit && elig[idx]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (grant == PORT_W'(i))
        head = rf_data_out[i*REC_W +: REC_W];
  end

  assign grant_elig = elig[grant];
  assign burst_more = burst_cnt < 4'(MAX_BURST);
  assign grant_next = (grant == PORT_W'(NUM_PORTS-1)) ? '0 : grant + 1'b1;

`ifdef UART_RX_ARB_DROP_ERR_EN
  logic drop_q;
  assign err_drop = drop_q;
`else
  assign err_drop = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      rr_ptr     <= '0;
      grant      <= '0;
      burst_cnt  <= '0;
      rf_pop     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_port   <= '0;
      out_status <= '0;
      grant_busy <= 1'b0;
`ifdef UART_RX_ARB_DROP_ERR_EN
      drop_q     <= 1'b0;
`endif
    end else begin
      rf_pop <= '0;
`ifdef UART_RX_ARB_DROP_ERR_EN
      drop_q <= 1'b0;
`endif
      case (state)
        ARB: begin
          if (hit) begin
            grant      <= hit_idx;
            burst_cnt  <= '0;
            grant_busy <= 1'b1;
            rf_pop     <= onehot(hit_idx);
            state      <= FETCH;
          end else begin
            grant_busy <= 1'b0;
          end
        end
        FETCH: begin
          // The pop strobe is live this cycle; head still shows the word being popped.
          burst_cnt <= burst_cnt + 4'd1;
`ifdef UART_RX_ARB_DROP_ERR_EN
          if (head[1] || head[0]) begin
            drop_q <= 1'b1;
            state  <= DROP;
          end else
`endif
          begin
            out_valid  <= 1'b1;
            out_data   <= head[REC_W-1 -: 8];
            out_port   <= grant;
            out_status <= head[2:0];
            state      <= OFFER;
          end
        end
        OFFER, DROP: begin
          // Count here already reflects the pop, so continuing never pops an empty FIFO.
          if (state == DROP || out_ready) begin
            out_valid <= 1'b0;
            if (burst_more && grant_elig) begin
              rf_pop <= onehot(grant);
              state  <= FETCH;
            end else begin
              rr_ptr     <= grant_next;
              grant_busy <= 1'b0;
              state      <= ARB;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Bench for uart_rx_arbiter: FIFO models, word-level round-robin scoreboard and directed scenarios.
module tb_uart_rx_arbiter;

  localparam int NP = 4;
  localparam int PW = 2;
  localparam int CW = 5;
  localparam int RW = 11;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    port_en = '1;
  logic [NP*CW-1:0] rf_count;
  logic [NP*RW-1:0] rf_data_out;
  logic [NP-1:0]    rf_pop;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic [PW-1:0]    out_port;
  logic [2:0]       out_status;
  logic             grant_busy;
  logic             err_drop;

  uart_rx_arbiter #(.NUM_PORTS(NP), .PORT_W(PW), .CNT_W(CW), .REC_W(RW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .port_en(port_en), .rf_count(rf_count), .rf_data_out(rf_data_out),
    .rf_pop(rf_pop), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_port(out_port), .out_status(out_status), .grant_busy(grant_busy), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  // FIFO models: mem/wr written by the stimulus, rd advanced by pops.
  logic [RW-1:0] mem [NP][256];
  int wr [NP];
  int rd [NP];
  int pop_cnt = 0;

  initial for (int i = 0; i < NP; i++) begin wr[i] = 0; rd[i] = 0; end

  always @(posedge clk)
    for (int i = 0; i < NP; i++)
      if (rf_pop[i]) begin
        rd[i]   <= rd[i] + 1;
        pop_cnt <= pop_cnt + 1;
      end

  always_comb begin
    rf_count    = '0;
    rf_data_out = '0;
    for (int i = 0; i < NP; i++) begin
      rf_count[i*CW +: CW] = CW'(wr[i] - rd[i]);
      if (wr[i] != rd[i]) rf_data_out[i*RW +: RW] = mem[i][rd[i] % 256];
    end
  end

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;
  logic [12:0] exp_q [$];
  logic [12:0] acc_log [$];
  int exp_drops = 0;
  int drop_seen = 0;

  // Word-level model: repeatedly grant the first eligible port from rr, take up to MB words.
  task automatic build_model(input logic [NP-1:0] en, input int rr0);
    int rdc [NP];
    int rr, p;
    bit found;
    logic [RW-1:0] w;
    for (int i = 0; i < NP; i++) rdc[i] = rd[i];
    rr = rr0;
    for (int guard = 0; guard < 1000; guard++) begin
      found = 1'b0;
      p = 0;
      for (int k = 0; k < NP; k++)
        if (!found && en[(rr + k) % NP] && rdc[(rr + k) % NP] != wr[(rr + k) % NP]) begin
          found = 1'b1;
          p = (rr + k) % NP;
        end
      if (!found) break;
      for (int n = 0; n < MB && rdc[p] != wr[p]; n++) begin
        w = mem[p][rdc[p] % 256];
        rdc[p]++;
`ifdef UART_RX_ARB_DROP_ERR_EN
        if (w[1] || w[0]) exp_drops++;
        else exp_q.push_back({PW'(p), w[10:3], w[2:0]});
`else
        exp_q.push_back({PW'(p), w[10:3], w[2:0]});
`endif
      end
      rr = (p + 1) % NP;
    end
  endtask

  // Per-cycle compare against the scoreboard and handshake rules.
  logic       hold_v = 1'b0;
  logic [12:0] hold_w;
  logic [12:0] e;
  always @(negedge clk) begin
    if (!chk_on) begin
      hold_v = 1'b0;
    end else begin
      checks++;
      if ($countones(rf_pop) > 1) begin
        errors++; $display("FAIL pop_onehot rf_pop=%b required at most one bit", rf_pop);
      end
      for (int i = 0; i < NP; i++)
        if (rf_pop[i]) begin
          checks++;
          if (wr[i] == rd[i]) begin
            errors++; $display("FAIL pop_empty port=%0d count=0 required nonzero", i);
          end
        end
      if (hold_v) begin
        checks++;
        if (!out_valid || {out_port, out_data, out_status} !== hold_w || rf_pop !== '0) begin
          errors++;
          $display("FAIL stall_hold valid=%b word=%h pop=%b required valid=1 word=%h pop=0",
                   out_valid, {out_port, out_data, out_status}, rf_pop, hold_w);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_word got=%h required none", {out_port, out_data, out_status});
        end else begin
          e = exp_q.pop_front();
          if ({out_port, out_data, out_status} !== e) begin
            errors++; $display("FAIL word_order got=%h required=%h", {out_port, out_data, out_status}, e);
          end
        end
        acc_log.push_back({out_port, out_data, out_status});
      end
`ifdef UART_RX_ARB_DROP_ERR_EN
      if (err_drop) drop_seen++;
`else
      checks++;
      if (err_drop !== 1'b0) begin
        errors++; $display("FAIL err_drop_tied got=%b required 0", err_drop);
      end
`endif
      hold_v = out_valid && !out_ready;
      hold_w = {out_port, out_data, out_status};
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int p, input logic [RW-1:0] w);
    mem[p][wr[p] % 256] = w;
    wr[p]++;
  endtask

  task automatic do_reset();
    chk_on = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) wr[i] = rd[i];
    exp_q.delete();
    acc_log.delete();
    exp_drops = 0;
    drop_seen = 0;
    port_en = '1;
    out_ready = 1'b1;
    chk_on = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || grant_busy) && n < budget) begin tick(); n++; end
    checks++;
    if (n >= budget) begin
      errors++; $display("FAIL %s_timeout pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk(out_valid, {name, "_wait_valid"}, 32'(out_valid), 32'd1);
  endtask

  int p0;

  initial begin
    // Reset values
    rst = 1'b1;
    #2;
    chk({rf_pop, out_valid, out_data, out_port, out_status, grant_busy, err_drop} == '0,
        "reset_outputs", {rf_pop, out_valid, grant_busy, err_drop}, 32'd0);

    // Single word on port 2, exact timing
    do_reset();
    push(2, 11'h5A8);
    build_model(4'b1111, 0);
    tick();
    chk(rf_pop == 4'b0100, "t1_pop", 32'(rf_pop), 32'h4);
    chk(grant_busy == 1'b1 && out_valid == 1'b0, "t1_fetch_busy", {grant_busy, out_valid}, 32'h2);
    tick();
    chk(rf_pop == 4'b0000, "t1_pop_single", 32'(rf_pop), 32'h0);
    chk(out_valid == 1'b1, "t1_valid", 32'(out_valid), 32'd1);
    chk(out_data == 8'hB5, "t1_data", 32'(out_data), 32'hB5);
    chk(out_port == 2'd2 && out_status == 3'b000, "t1_tag", {out_port, out_status}, 32'h10);
    tick();
    chk(out_valid == 1'b0 && grant_busy == 1'b0, "t1_release", {out_valid, grant_busy}, 32'h0);
    // rr_ptr now 3: port 3 must win over port 0
    push(0, 11'h123);
    push(3, 11'h456);
    build_model(4'b1111, 3);
    tick();
    chk(rf_pop == 4'b1000, "t1_rr_ptr3", 32'(rf_pop), 32'h8);
    drain("t1", 50);

    // All ports 8 deep, bursts of 4
    do_reset();
    for (int p = 0; p < NP; p++)
      for (int j = 0; j < 8; j++) push(p, {4'(p), 4'(j), 3'b000});
    p0 = pop_cnt;
    build_model(4'b1111, 0);
    drain("t2", 400);
    chk(pop_cnt - p0 == 32, "t2_pop_total", 32'(pop_cnt - p0), 32'd32);
    chk(acc_log.size() == 32, "t2_words", 32'(acc_log.size()), 32'd32);
    if (acc_log.size() >= 9)
      chk(acc_log[0][12:11] == 0 && acc_log[3][12:11] == 0 && acc_log[4][12:11] == 1 &&
          acc_log[7][12:11] == 1 && acc_log[8][12:11] == 2 && acc_log[3][10:3] == 8'h03,
          "t2_order", {acc_log[3], acc_log[4][12:11], acc_log[8][12:11]}, 32'h0);

    // Downstream stall for 10 cycles mid-offer
    do_reset();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) push(1, {4'h1, 4'(j + 1), 3'b000});
    build_model(4'b1111, 0);
    wait_valid("t3");
    p0 = pop_cnt;
    repeat (10) tick();
    chk(pop_cnt == p0, "t3_no_pop_stall", 32'(pop_cnt - p0), 32'd0);
    chk(out_valid && out_data == 8'h11 && out_port == 2'd1, "t3_held", {out_valid, out_data}, 32'h111);
    out_ready = 1'b1;
    drain("t3", 60);

    // Only ports 1 and 3 enabled
    do_reset();
    port_en = 4'b1010;
    for (int p = 0; p < NP; p++)
      for (int j = 0; j < 5; j++) push(p, {4'(p), 4'(j), 3'b000});
    build_model(4'b1010, 0);
    drain("t4", 200);
    chk(acc_log.size() == 10, "t4_words", 32'(acc_log.size()), 32'd10);
    if (acc_log.size() == 10)
      chk(acc_log[0][12:11] == 1 && acc_log[3][12:11] == 1 && acc_log[4][12:11] == 3 &&
          acc_log[7][12:11] == 3 && acc_log[8][12:11] == 1 && acc_log[9][12:11] == 3,
          "t4_order", {acc_log[8][12:11], acc_log[9][12:11]}, 32'h7);
    chk(wr[0] - rd[0] == 5 && wr[2] - rd[2] == 5, "t4_disabled_untouched", 32'(wr[0] - rd[0]), 32'd5);

    // Framing-error word on port 0
    do_reset();
    push(0, 11'h001);
    push(1, 11'h3F8);
    p0 = pop_cnt;
    build_model(4'b1111, 0);
    drain("t5", 60);
    chk(pop_cnt - p0 == 2, "t5_pops", 32'(pop_cnt - p0), 32'd2);
`ifdef UART_RX_ARB_DROP_ERR_EN
    chk(drop_seen == 1 && exp_drops == 1, "t5_err_drop", 32'(drop_seen), 32'd1);
    chk(acc_log.size() == 1 && acc_log[0] == {2'd1, 8'h7F, 3'b000}, "t5_forward_only", 32'(acc_log.size()), 32'd1);
`else
    chk(acc_log.size() == 2, "t5_words", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2)
      chk(acc_log[0] == {2'd0, 8'h00, 3'b001}, "t5_status_fwd", 32'(acc_log[0]), 32'h1);
`endif

    // Async reset during OFFER, then restart at port 0
    do_reset();
    out_ready = 1'b0;
    push(1, 11'h0A8);
    push(2, 11'h0B0);
    push(2, 11'h0B8);
    build_model(4'b1111, 0);
    wait_valid("t6a");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid("t6b");
    chk(out_port == 2'd2 && grant_busy, "t6_offer_port2", 32'(out_port), 32'd2);
    chk_on = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk(out_valid == 1'b0 && rf_pop == '0 && grant_busy == 1'b0, "t6_async_rst",
        {out_valid, rf_pop, grant_busy}, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) wr[i] = rd[i];
    exp_q.delete();
    acc_log.delete();
    out_ready = 1'b1;
    chk_on = 1'b1;
    push(3, 11'h2A0);
    push(0, 11'h2A8);
    build_model(4'b1111, 0);
    drain("t6", 60);
    chk(acc_log.size() == 2 && acc_log[0][12:11] == 0, "t6_restart_port0", 32'(acc_log.size()), 32'd2);

    chk(exp_q.size() == 0, "final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
